// File: rtl/alu_issue_arbiter_pkg.sv
// Shared defaults and in-flight entry type for the ALU issue arbiter.
package alu_issue_arbiter_pkg;

   localparam int ALU_ARB_NUM_REQ = 8;
   localparam int ALU_ARB_NUM_FU  = 2;
   localparam int ALU_FU_LATENCY  = 2;
   localparam int ALU_ARB_IDX_W   = $clog2(ALU_ARB_NUM_REQ);

   // req_idx is sized for the default requester count
   typedef struct packed {
      logic                     valid;
      logic [ALU_ARB_IDX_W-1:0] req_idx;
   } ALU_INFLIGHT_ENTRY;

endpackage

// File: rtl/alu_issue_arbiter_rr_priority_pick.sv
// Round-robin picker: first NUM_PICK set requesters scanning up from rr_ptr, with wrap.
module rr_priority_pick #(
   parameter  int NUM_REQ  = 8,
   parameter  int NUM_PICK = 2,
   localparam int IDX_W    = $clog2(NUM_REQ),
   localparam int PCNT_W   = $clog2(NUM_PICK + 1)
) (
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [IDX_W-1:0]                   rr_ptr,
   output logic [NUM_PICK-1:0][IDX_W-1:0]     pick_idx,
   output logic [PCNT_W-1:0]                  pick_cnt
);

   always_comb begin
      int               cnt;
      logic [IDX_W-1:0] idx;
      pick_idx = '0;
      cnt      = 0;
      idx      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // IDX_W-bit add wraps modulo NUM_REQ
         idx = rr_ptr + IDX_W'(i);
         if (req_valid[idx] && cnt < NUM_PICK) begin
            pick_idx[cnt] = idx;
            cnt++;
         end
      end
      pick_cnt = PCNT_W'(cnt);
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Grants ready RS entries onto NUM_FU pipelined ALUs and tracks them to writeback.
// Optional perf counters enabled by defining ALU_ARB_PERF_EN.
module alu_issue_arbiter
   import alu_issue_arbiter_pkg::*;
#(
   parameter  int NUM_REQ    = ALU_ARB_NUM_REQ,
   parameter  int NUM_FU     = ALU_ARB_NUM_FU,
   parameter  int FU_LATENCY = ALU_FU_LATENCY,
   localparam int IDX_W      = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(NUM_FU * FU_LATENCY) + 1,
   localparam int PCNT_W     = $clog2(NUM_FU + 1)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_FU-1:0]              fu_stall,
   input  logic                           squash,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_FU-1:0]              issue_valid,
   output logic [NUM_FU-1:0][IDX_W-1:0]   issue_req_idx,
   output logic [NUM_FU-1:0]              wb_valid,
   output logic [NUM_FU-1:0][IDX_W-1:0]   wb_req_idx,
   output logic [CNT_W-1:0]               inflight_cnt
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [31:0]                    perf_grants,
   output logic [31:0]                    perf_conflict_cycles
`endif
);

   logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
   ALU_INFLIGHT_ENTRY [NUM_FU-1:0][FU_LATENCY-1:0] pipe_q, pipe_d;
   logic [CNT_W-1:0]                  inflight_cnt_q, inflight_cnt_d;
   logic [NUM_FU-1:0][IDX_W-1:0]      pick_idx;
   logic [PCNT_W-1:0]                 pick_cnt;

   rr_priority_pick #(
      .NUM_REQ  (NUM_REQ),
      .NUM_PICK (NUM_FU)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .pick_idx  (pick_idx),
      .pick_cnt  (pick_cnt)
   );

   // n-th pick goes to the n-th unstalled FU; extra picks are simply dropped
   always_comb begin
      int slot;
      grant         = '0;
      issue_valid   = '0;
      issue_req_idx = '0;
      rr_ptr_d      = rr_ptr_q;
      slot          = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (reset && !squash && !fu_stall[k] && slot < int'(pick_cnt)) begin
            issue_valid[k]          = 1'b1;
            issue_req_idx[k]        = pick_idx[slot];
            grant[pick_idx[slot]]   = 1'b1;
            rr_ptr_d                = pick_idx[slot] + IDX_W'(1);
            slot++;
         end
      end
   end

   always_comb begin
      int cnt;
      pipe_d = pipe_q;
      cnt    = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (squash) begin
            pipe_d[k] = '0;
         end else if (!fu_stall[k]) begin
            pipe_d[k][0].valid   = issue_valid[k];
            pipe_d[k][0].req_idx = ALU_ARB_IDX_W'(issue_req_idx[k]);
            for (int s = 1; s < FU_LATENCY; s++)
               pipe_d[k][s] = pipe_q[k][s-1];
         end
         for (int s = 0; s < FU_LATENCY; s++)
            if (pipe_d[k][s].valid) cnt++;
      end
      inflight_cnt_d = CNT_W'(cnt);
   end

   always_comb begin
      for (int k = 0; k < NUM_FU; k++) begin
         wb_valid[k]   = pipe_q[k][FU_LATENCY-1].valid;
         wb_req_idx[k] = IDX_W'(pipe_q[k][FU_LATENCY-1].req_idx);
      end
   end

   assign inflight_cnt = inflight_cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q       <= '0;
         pipe_q         <= '0;
         inflight_cnt_q <= '0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         pipe_q         <= pipe_d;
         inflight_cnt_q <= inflight_cnt_d;
      end
   end

`ifdef ALU_ARB_PERF_EN
   logic [31:0] perf_grants_q, perf_grants_d;
   logic [31:0] perf_conflict_q, perf_conflict_d;

   always_comb begin
      logic [31:0] n_grant;
      n_grant         = 32'($countones(grant));
      perf_grants_d   = perf_grants_q;
      perf_conflict_d = perf_conflict_q;
      if (32'hFFFF_FFFF - perf_grants_q >= n_grant)
         perf_grants_d = perf_grants_q + n_grant;
      else
         perf_grants_d = '1;
      if (!squash && $countones(req_valid) > $countones(grant) && perf_conflict_q != '1)
         perf_conflict_d = perf_conflict_q + 32'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_grants_q   <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_grants_q   <= perf_grants_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_grants          = perf_grants_q;
   assign perf_conflict_cycles = perf_conflict_q;
`else
   // counters and their ports are not built
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed self-checking bench for alu_issue_arbiter (default parameters).
module tb_alu_issue_arbiter;

   logic                clock;
   logic                reset;
   logic [7:0]          req_valid;
   logic [1:0]          fu_stall;
   logic                squash;
   logic [7:0]          grant;
   logic [1:0]          issue_valid;
   logic [1:0][2:0]     issue_req_idx;
   logic [1:0]          wb_valid;
   logic [1:0][2:0]     wb_req_idx;
   logic [2:0]          inflight_cnt;
`ifdef ALU_ARB_PERF_EN
   logic [31:0]         perf_grants;
   logic [31:0]         perf_conflict_cycles;
`endif

   int checks = 0;
   int errors = 0;

   alu_issue_arbiter dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .fu_stall      (fu_stall),
      .squash        (squash),
      .grant         (grant),
      .issue_valid   (issue_valid),
      .issue_req_idx (issue_req_idx),
      .wb_valid      (wb_valid),
      .wb_req_idx    (wb_req_idx),
      .inflight_cnt  (inflight_cnt)
`ifdef ALU_ARB_PERF_EN
      ,
      .perf_grants          (perf_grants),
      .perf_conflict_cycles (perf_conflict_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic do_reset();
      reset = 1'b0; req_valid = '0; fu_stall = '0; squash = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 8'hFF; fu_stall = '0; squash = 1'b0;
      #1;
      checks++; if (grant !== 8'h00) begin errors++; $display("FAIL rst_grant got %h exp %h", grant, 8'h00); end
      checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL rst_issue_valid got %b exp %b", issue_valid, 2'b00); end
      checks++; if (wb_valid !== 2'b00 || wb_req_idx !== 6'h00) begin errors++; $display("FAIL rst_wb got %b/%h exp 00/00", wb_valid, wb_req_idx); end
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL rst_inflight got %0d exp 0", inflight_cnt); end
      @(negedge clock);
      reset = 1'b1;
      #1;
      checks++; if (grant !== 8'h03 || issue_valid !== 2'b11 || issue_req_idx !== 6'h08) begin errors++; $display("FAIL first_grant got %h/%b/%h exp 03/11/08", grant, issue_valid, issue_req_idx); end
      @(negedge clock); #1;
      checks++; if (grant !== 8'h0C || issue_req_idx !== 6'h1A) begin errors++; $display("FAIL second_grant got %h/%h exp 0c/1a", grant, issue_req_idx); end
      @(negedge clock); #1;
      checks++; if (grant !== 8'h30) begin errors++; $display("FAIL rr_ptr4_grant got %h exp 30", grant); end
      checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL inflight_full got %0d exp 4", inflight_cnt); end
      checks++; if (wb_valid !== 2'b11 || wb_req_idx !== 6'h08) begin errors++; $display("FAIL first_wb got %b/%h exp 11/08", wb_valid, wb_req_idx); end
   endtask

   task automatic test_single_issue();
      do_reset();
      req_valid = 8'h20; #1;
      checks++; if (grant !== 8'h20 || issue_valid !== 2'b01 || issue_req_idx[0] !== 3'd5) begin errors++; $display("FAIL single_issue got %h/%b/%0d exp 20/01/5", grant, issue_valid, issue_req_idx[0]); end
      @(negedge clock); req_valid = '0; #1;
      checks++; if (wb_valid !== 2'b00 || inflight_cnt !== 3'd1) begin errors++; $display("FAIL single_t1 got %b/%0d exp 00/1", wb_valid, inflight_cnt); end
      @(negedge clock); #1;
      checks++; if (wb_valid !== 2'b01 || wb_req_idx[0] !== 3'd5 || inflight_cnt !== 3'd1) begin errors++; $display("FAIL single_wb got %b/%0d/%0d exp 01/5/1", wb_valid, wb_req_idx[0], inflight_cnt); end
      @(negedge clock); #1;
      checks++; if (wb_valid !== 2'b00 || inflight_cnt !== 3'd0) begin errors++; $display("FAIL single_drain got %b/%0d exp 00/0", wb_valid, inflight_cnt); end
   endtask

   task automatic test_stall();
      do_reset();
      req_valid = 8'h10; #1;
      checks++; if (issue_valid !== 2'b01 || issue_req_idx[0] !== 3'd4) begin errors++; $display("FAIL stall_pre got %b/%0d exp 01/4", issue_valid, issue_req_idx[0]); end
      @(negedge clock); req_valid = 8'h03; fu_stall = 2'b01; #1;
      checks++; if (grant !== 8'h01 || issue_valid !== 2'b10 || issue_req_idx[1] !== 3'd0) begin errors++; $display("FAIL stall_grant got %h/%b/%0d exp 01/10/0", grant, issue_valid, issue_req_idx[1]); end
      @(negedge clock); req_valid = '0; fu_stall = 2'b01; #1;
      checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL stall_hold got %b exp 00", wb_valid); end
      @(negedge clock); fu_stall = 2'b00; #1;
      checks++; if (wb_valid !== 2'b10 || wb_req_idx[1] !== 3'd0 || inflight_cnt !== 3'd2) begin errors++; $display("FAIL stall_fu1_wb got %b/%0d/%0d exp 10/0/2", wb_valid, wb_req_idx[1], inflight_cnt); end
      @(negedge clock); #1;
      checks++; if (wb_valid !== 2'b01 || wb_req_idx[0] !== 3'd4) begin errors++; $display("FAIL stall_late_wb got %b/%0d exp 01/4", wb_valid, wb_req_idx[0]); end
   endtask

   task automatic test_wrap();
      do_reset();
      req_valid = 8'h40;
      @(negedge clock); req_valid = 8'h81; #1;
      checks++; if (grant !== 8'h81 || issue_valid !== 2'b11 || issue_req_idx !== 6'h07) begin errors++; $display("FAIL wrap_grant got %h/%b/%h exp 81/11/07", grant, issue_valid, issue_req_idx); end
      @(negedge clock); req_valid = 8'h03; #1;
      checks++; if (grant !== 8'h03 || issue_req_idx !== 6'h01) begin errors++; $display("FAIL wrap_ptr1 got %h/%h exp 03/01", grant, issue_req_idx); end
   endtask

   task automatic test_squash();
      do_reset();
      req_valid = 8'h03;
      @(negedge clock); req_valid = 8'hFF; squash = 1'b1; fu_stall = 2'b01; #1;
      checks++; if (grant !== 8'h00 || issue_valid !== 2'b00) begin errors++; $display("FAIL squash_grant got %h/%b exp 00/00", grant, issue_valid); end
      checks++; if (inflight_cnt !== 3'd2) begin errors++; $display("FAIL squash_pre_cnt got %0d exp 2", inflight_cnt); end
      @(negedge clock); req_valid = '0; squash = 1'b0; fu_stall = '0; #1;
      checks++; if (wb_valid !== 2'b00 || inflight_cnt !== 3'd0) begin errors++; $display("FAIL squash_t1 got %b/%0d exp 00/0", wb_valid, inflight_cnt); end
      @(negedge clock); #1;
      checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL squash_t2 got %b exp 00", wb_valid); end
   endtask

   task automatic test_all_stall();
      do_reset();
      req_valid = 8'h04;
      @(negedge clock); req_valid = 8'hFF; fu_stall = 2'b11; #1;
      checks++; if (grant !== 8'h00 || issue_valid !== 2'b00) begin errors++; $display("FAIL allstall_grant got %h/%b exp 00/00", grant, issue_valid); end
      @(negedge clock); req_valid = 8'h05; fu_stall = 2'b00; #1;
      checks++; if (grant !== 8'h05 || issue_req_idx !== 6'h10) begin errors++; $display("FAIL allstall_ptr got %h/%h exp 05/10", grant, issue_req_idx); end
   endtask

`ifdef ALU_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      #1;
      checks++; if (perf_grants !== 32'd0 || perf_conflict_cycles !== 32'd0) begin errors++; $display("FAIL perf_rst got %0d/%0d exp 0/0", perf_grants, perf_conflict_cycles); end
      req_valid = 8'h07;
      repeat (10) @(negedge clock);
      req_valid = '0; #1;
      checks++; if (perf_grants !== 32'd20) begin errors++; $display("FAIL perf_grants got %0d exp 20", perf_grants); end
      checks++; if (perf_conflict_cycles !== 32'd10) begin errors++; $display("FAIL perf_conflict got %0d exp 10", perf_conflict_cycles); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_issue();
      test_stall();
      test_wrap();
      test_squash();
      test_all_stall();
`ifdef ALU_ARB_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
